// File: rtl/lsu.sv
// Load/store unit: turns one byte/half/word request into an aligned 32-bit memory
// access, waits out memory busy with an optional timeout, and returns an extended result.
module lsu #(
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_rstrb,
  output logic        mem_wstrb,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rbusy,
  input  logic        mem_wbusy
);

  localparam int unsigned CW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [CW-1:0] WAIT_LIM = CW'(WAIT_MAX);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          is_load_q, is_load_d;
  logic [31:0]   addr_q, addr_d;
  logic [2:0]    f3_q, f3_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          aligned;
  logic          f3_ok;
  logic          legal;
  logic          mbusy;
  logic [CW-1:0] cnt_inc;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_ext;
  logic          active;
  logic [3:0]    st_mask;
  logic [31:0]   st_data;

  // Request legality is judged on the raw inputs in the IDLE sampling cycle.
  always_comb begin
    case (req_funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~req_addr[0];
      2'b10:   aligned = (req_addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  assign f3_ok = req_load ? (req_funct3[2:1] != 2'b11) : ~req_funct3[2];
  assign legal = (req_load ^ req_store) & aligned & f3_ok;

  assign mbusy   = is_load_q ? mem_rbusy : mem_wbusy;
  assign cnt_inc = cnt_q + 1'b1;

  assign ld_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    case (f3_q[1:0])
      2'b00:   ld_ext = {{24{~f3_q[2] & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{~f3_q[2] & ld_half[15]}}, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    is_load_d = is_load_q;
    addr_d    = addr_q;
    f3_d      = f3_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_load | req_store) begin
          is_load_d = req_load & ~req_store;
          addr_d    = req_addr;
          f3_d      = req_funct3;
          wdata_d   = req_wdata;
          if (legal) begin
            state_d = S_ISSUE;
            err_d   = 1'b0;
          end else begin
            state_d = S_RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (!mbusy) begin
          state_d = S_RESP;
          err_d   = 1'b0;
          if (is_load_q) rdata_d = ld_ext;
        end else begin
          cnt_d = cnt_inc;
          if ((WAIT_MAX != 0) && (cnt_inc == WAIT_LIM)) begin
            state_d = S_RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      is_load_q <= 1'b0;
      addr_q    <= '0;
      f3_q      <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      is_load_q <= is_load_d;
      addr_q    <= addr_d;
      f3_q      <= f3_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
    end
  end

  // Store lanes: data is replicated so the mask alone selects the written bytes.
  always_comb begin
    case (f3_q[1:0])
      2'b00: begin
        st_mask = 4'b0001 << addr_q[1:0];
        st_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        st_mask = addr_q[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wdata_q[15:0]}};
      end
      default: begin
        st_mask = 4'b1111;
        st_data = wdata_q;
      end
    endcase
  end

  assign active    = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_err   = (state_q == S_RESP) & err_q;
  assign rsp_rdata = rdata_q;
  assign mem_addr  = active ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_rstrb = (state_q == S_ISSUE) & is_load_q;
  assign mem_wstrb = (state_q == S_ISSUE) & ~is_load_q;
  assign mem_wmask = (active && !is_load_q) ? st_mask : 4'b0000;
  assign mem_wdata = (active && !is_load_q) ? st_data : 32'h0;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: table of single-request vectors plus hand-built
// busy, timeout, reset and ignored-request sequences.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_load = 1'b0;
  logic        req_store = 1'b0;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_wdata = '0;
  logic        busy, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata;
  logic        mem_rstrb, mem_wstrb;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata = '0;
  logic        mem_rbusy = 1'b0;
  logic        mem_wbusy = 1'b0;

  int tests = 0;
  int fails = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int rsp_cnt = 0;

  lsu #(.WAIT_MAX(4)) dut (
    .clk(clk), .rstn(rstn),
    .req_load(req_load), .req_store(req_store), .req_addr(req_addr),
    .req_funct3(req_funct3), .req_wdata(req_wdata),
    .busy(busy), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_rstrb(mem_rstrb), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
    .mem_rbusy(mem_rbusy), .mem_wbusy(mem_wbusy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_rstrb) rd_cnt++;
    if (mem_wstrb) wr_cnt++;
    if (rsp_valid) rsp_cnt++;
  end

  typedef struct {
    bit          ld;
    bit          st;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
    logic [31:0] maddr;
    logic [3:0]  mask;
    logic [31:0] mwdata;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_vec(input int i);
    vec_t v;
    v = vecs[i];
    mem_rdata  = v.rdata;
    req_load   = v.ld;
    req_store  = v.st;
    req_addr   = v.addr;
    req_funct3 = v.f3;
    req_wdata  = v.wdata;
    tick();
    req_load  = 1'b0;
    req_store = 1'b0;
    if (v.err) begin
      chk("err_valid", {31'b0, rsp_valid}, 32'd1);
      chk("err_flag", {31'b0, rsp_err}, 32'd1);
      chk("err_rdata", rsp_rdata, 32'h0);
      chk("err_strobe", {30'b0, mem_rstrb, mem_wstrb}, 32'd0);
      chk("err_addr", mem_addr, 32'h0);
    end else begin
      chk("issue_busy", {31'b0, busy}, 32'd1);
      chk("issue_rstrb", {31'b0, mem_rstrb}, {31'b0, v.ld});
      chk("issue_wstrb", {31'b0, mem_wstrb}, {31'b0, v.st});
      chk("issue_addr", mem_addr, v.maddr);
      chk("issue_mask", {28'b0, mem_wmask}, {28'b0, v.mask});
      chk("issue_wdata", mem_wdata, v.mwdata);
      tick();
      chk("wait_strobe", {30'b0, mem_rstrb, mem_wstrb}, 32'd0);
      chk("wait_addr", mem_addr, v.maddr);
      chk("wait_valid", {31'b0, rsp_valid}, 32'd0);
      tick();
      chk("resp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("resp_err", {31'b0, rsp_err}, 32'd0);
      chk("resp_rdata", rsp_rdata, v.exp);
      chk("resp_addr", mem_addr, 32'h0);
    end
    tick();
    chk("idle_busy", {31'b0, busy}, 32'd0);
    chk("idle_valid", {31'b0, rsp_valid}, 32'd0);
    $display("[TB] vec %0d ld=%0b st=%0b addr=%h f3=%0d rdata=%h", i, v.ld, v.st, v.addr, v.f3, rsp_rdata);
  endtask

  // Runs one request; memory busy is held high for nbusy WAIT cycles.
  task automatic txn(input bit ld, input bit st, input logic [31:0] addr, input logic [2:0] f3,
                     input logic [31:0] wd, input logic [31:0] rd, input int nbusy, input bit poke,
                     output int lat, output logic err, output logic [31:0] rdo);
    int k;
    lat = -1;
    err = 1'b0;
    rdo = '0;
    mem_rdata  = rd;
    req_load   = ld;
    req_store  = st;
    req_addr   = addr;
    req_funct3 = f3;
    req_wdata  = wd;
    tick();
    req_load  = 1'b0;
    req_store = 1'b0;
    k = 0;
    while (k < 30) begin
      mem_rbusy = ld && (k + 1 >= 2) && (k + 1 <= 1 + nbusy);
      mem_wbusy = st && (k + 1 >= 2) && (k + 1 <= 1 + nbusy);
      if (poke) begin
        req_load   = (k + 1 == 2);
        req_addr   = 32'h40;
        req_funct3 = 3'd2;
      end
      if (rsp_valid) begin
        lat = k + 1;
        err = rsp_err;
        rdo = rsp_rdata;
        break;
      end
      tick();
      k++;
    end
    req_load  = 1'b0;
    mem_rbusy = 1'b0;
    mem_wbusy = 1'b0;
    tick();
    $display("[TB] txn ld=%0b st=%0b addr=%h busy=%0d lat=%0d err=%0b rdata=%h", ld, st, addr, nbusy, lat, err, rdo);
  endtask

  initial begin
    int lat;
    logic err;
    logic [31:0] rdo;
    int snap;

    vecs[0]  = '{1, 0, 32'h104, 3'd2, 32'h0,        32'hDEADBEEF, 0, 32'h104, 4'h0, 32'h0,        32'hDEADBEEF};
    vecs[1]  = '{1, 0, 32'h103, 3'd0, 32'h0,        32'h80123456, 0, 32'h100, 4'h0, 32'h0,        32'hFFFFFF80};
    vecs[2]  = '{1, 0, 32'h103, 3'd4, 32'h0,        32'h80123456, 0, 32'h100, 4'h0, 32'h0,        32'h00000080};
    vecs[3]  = '{1, 0, 32'h102, 3'd1, 32'h0,        32'h80123456, 0, 32'h100, 4'h0, 32'h0,        32'hFFFF8012};
    vecs[4]  = '{1, 0, 32'h100, 3'd5, 32'h0,        32'h80123456, 0, 32'h100, 4'h0, 32'h0,        32'h00003456};
    vecs[5]  = '{0, 1, 32'h201, 3'd0, 32'h000000AB, 32'h0,        0, 32'h200, 4'h2, 32'hABABABAB, 32'h00003456};
    vecs[6]  = '{0, 1, 32'h202, 3'd1, 32'h00001234, 32'h0,        0, 32'h200, 4'hC, 32'h12341234, 32'h00003456};
    vecs[7]  = '{0, 1, 32'h300, 3'd2, 32'hCAFEF00D, 32'h0,        0, 32'h300, 4'hF, 32'hCAFEF00D, 32'h00003456};
    vecs[8]  = '{1, 0, 32'h102, 3'd2, 32'h0,        32'hDEADBEEF, 1, 32'h0,   4'h0, 32'h0,        32'h0};
    vecs[9]  = '{1, 0, 32'h102, 3'd1, 32'h0,        32'h7FFF1234, 0, 32'h100, 4'h0, 32'h0,        32'h00007FFF};
    vecs[10] = '{1, 0, 32'h101, 3'd1, 32'h0,        32'h7FFF1234, 1, 32'h0,   4'h0, 32'h0,        32'h0};
    vecs[11] = '{1, 0, 32'h100, 3'd3, 32'h0,        32'h7FFF1234, 1, 32'h0,   4'h0, 32'h0,        32'h0};
    vecs[12] = '{1, 1, 32'h100, 3'd2, 32'h0,        32'h7FFF1234, 1, 32'h0,   4'h0, 32'h0,        32'h0};
    vecs[13] = '{0, 1, 32'h203, 3'd2, 32'h11111111, 32'h0,        1, 32'h0,   4'h0, 32'h0,        32'h0};
    vecs[14] = '{0, 1, 32'h100, 3'd4, 32'h11111111, 32'h0,        1, 32'h0,   4'h0, 32'h0,        32'h0};
    vecs[15] = '{1, 0, 32'h100, 3'd6, 32'h0,        32'hFFFFFFFF, 1, 32'h0,   4'h0, 32'h0,        32'h0};
    vecs[16] = '{0, 1, 32'h203, 3'd0, 32'h0000005A, 32'h0,        0, 32'h200, 4'h8, 32'h5A5A5A5A, 32'h0};

    #12;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_mem", {mem_addr[31:6], mem_rstrb, mem_wstrb, mem_wmask}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) do_vec(i);

    snap = wr_cnt;
    txn(0, 1, 32'h10, 3'd2, 32'h11223344, 32'h0, 3, 0, lat, err, rdo);
    chk("wbusy_lat", lat, 32'd6);
    chk("wbusy_err", {31'b0, err}, 32'd0);
    chk("wbusy_strobes", wr_cnt - snap, 32'd1);

    snap = rd_cnt;
    txn(1, 0, 32'h20, 3'd2, 32'h0, 32'h0, 100, 0, lat, err, rdo);
    chk("tmo_lat", lat, 32'd6);
    chk("tmo_err", {31'b0, err}, 32'd1);
    chk("tmo_rdata", rdo, 32'h0);
    chk("tmo_strobes", rd_cnt - snap, 32'd1);

    txn(1, 0, 32'h8, 3'd2, 32'h0, 32'h12345678, 0, 0, lat, err, rdo);
    chk("after_tmo_lat", lat, 32'd3);
    chk("after_tmo_err", {31'b0, err}, 32'd0);
    chk("after_tmo_rdata", rdo, 32'h12345678);

    // Reset while the access sits in WAIT.
    mem_rbusy  = 1'b1;
    req_load   = 1'b1;
    req_addr   = 32'h24;
    req_funct3 = 3'd2;
    tick();
    req_load = 1'b0;
    tick();
    chk("pre_rst_busy", {31'b0, busy}, 32'd1);
    chk("pre_rst_addr", mem_addr, 32'h24);
    snap = rsp_cnt;
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_addr", mem_addr, 32'h0);
    chk("mid_rst_rdata", rsp_rdata, 32'h0);
    chk("mid_rst_strb", {30'b0, mem_rstrb, mem_wstrb}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    mem_rbusy = 1'b0;
    tick();
    chk("mid_rst_no_rsp", rsp_cnt - snap, 32'd0);
    $display("[TB] reset during WAIT applied");

    txn(1, 0, 32'h44, 3'd2, 32'h0, 32'hA5A5A5A5, 0, 0, lat, err, rdo);
    chk("post_rst_lat", lat, 32'd3);
    chk("post_rst_rdata", rdo, 32'hA5A5A5A5);

    // Load pulsed mid-store must be dropped.
    snap = rd_cnt;
    txn(0, 1, 32'h50, 3'd2, 32'h99887766, 32'h0, 2, 1, lat, err, rdo);
    chk("poke_lat", lat, 32'd5);
    tick();
    tick();
    chk("poke_busy", {31'b0, busy}, 32'd0);
    chk("poke_no_load", rd_cnt - snap, 32'd0);
    chk("poke_rdata", rsp_rdata, 32'hA5A5A5A5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly downstream of the multi-cycle `mcu` core, between its execute stage and the word-addressed data memory. Accepts one byte/halfword/word load or store request at a time. Converts each request into an aligned 32-bit bus access with a byte write mask, waits out memory busy signals with a timeout, and returns the sign- or zero-extended load result with a one-cycle completion pulse.

## Interface

- `WAIT_MAX`, default 255: number of consecutive busy cycles in WAIT before the access aborts with an error; 0 disables the timeout.

- `clk`  in  1  system clock, rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `req_load`  in  1  start a load; sampled only in IDLE.
- `req_store`  in  1  start a store; sampled only in IDLE.
- `req_addr`  in  32  byte address (rs1 + imm).
- `req_funct3`  in  3  RISC-V funct3 of the LOAD/STORE instruction.
- `req_wdata`  in  32  store data (rs2).
- `busy`  out  1  high whenever state is not IDLE.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_err`  out  1  valid with `rsp_valid`: misaligned, illegal funct3, conflicting request, or timeout.
- `rsp_rdata`  out  32  extended load result; held until the next completion.
- `mem_addr`  out  32  word address, bits [1:0] always 0.
- `mem_rstrb`  out  1  read strobe, exactly one cycle per load.
- `mem_wstrb`  out  1  write strobe, exactly one cycle per store.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_wmask`  out  4  byte write enables.
- `mem_rdata`  in  32  read data, valid in the cycle `mem_rbusy` is low.
- `mem_rbusy`  in  1  read not yet complete.
- `mem_wbusy`  in  1  write not yet complete.

## Operation

- States: IDLE, ISSUE, WAIT, RESP.
- IDLE behaviour:
  - Request when exactly one of `req_load`/`req_store` is high. Latch addr, funct3, and wdata.
  - Both high: error response, no memory access.
- Legality check in the request cycle:
  - funct3[1:0]=00 is always aligned.
  - 01 needs addr[0]=0.
  - 10 needs addr[1:0]=00.
  - 11 is illegal.
  - Loads: funct3 110/111 are illegal.
  - Stores: funct3[2]=1 is illegal.
  - An illegal or misaligned request goes IDLE→RESP with the error flag and no strobe.
- Legal request goes IDLE→ISSUE.
- ISSUE:
  - Assert `mem_rstrb` (load) or `mem_wstrb` (store) for one cycle, then →WAIT.
  - `mem_addr` = {addr[31:2],2'b00}.
- Store masks and data:
  - Byte: mask = 4'b0001<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - Half: mask = addr[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}.
  - Word: mask = 1111, wdata as-is.
- Loads: `mem_wmask`=0000.
- `mem_addr`, `mem_wmask`, and `mem_wdata` hold from ISSUE through WAIT. They are 0 in IDLE/RESP.
- WAIT:
  - Watch `mem_rbusy` for loads and `mem_wbusy` for stores.
  - Busy low: capture `mem_rdata` (loads) and go →RESP.
  - Busy high: increment the timeout counter. When the counter reaches `WAIT_MAX` (if nonzero), go →RESP with the error flag.
- Load extraction from the captured word:
  - Byte: lane addr[1:0].
  - Half: lane addr[1].
  - Sign-extend when funct3[2]=0, else zero-extend.
- RESP:
  - `rsp_valid`=1 for one cycle, `rsp_err` = error flag, then →IDLE.
  - `rsp_rdata` takes the extracted value on a successful load, 0 on any error, and is unchanged on a successful store.
- Requests while `busy`=1 are ignored. The core issues only when `busy`=0.
- Timeout counter:
  - Width $clog2(WAIT_MAX+1), minimum 1.
  - Cleared on entry to WAIT.

## Timing

- Reset, asynchronous: state IDLE, counter 0, all outputs 0 (`rsp_rdata` = 0).
- Reset mid-access: strobes and `busy` drop immediately, no `rsp_valid`, and the in-flight request is lost.
- Request sampled at edge N (cycle N in IDLE). Subsequent cycles:
  - ISSUE in cycle N+1.
  - WAIT from N+2.
  - RESP in N+3 + (busy cycles).
- Zero-wait access: `rsp_valid` 3 cycles after the request cycle.
- Error at decode: RESP in cycle N+1.
- Timeout: RESP in cycle N+2+`WAIT_MAX`.
- `busy` is high from N+1 through RESP inclusive. A new request is accepted in the cycle after RESP.
- All outputs are decoded from registered state and latched fields. There are no combinational paths from `req_*` or `mem_*busy` to outputs.

## Test plan

- LW addr 0x104, `mem_rdata`=0xDEADBEEF, rbusy=0 → `mem_addr`=0x104, `mem_rstrb` only in N+1, `rsp_valid` in N+3, `rsp_rdata`=0xDEADBEEF, `rsp_err`=0.
- `mem_rdata`=0x80123456:
  - LB 0x103 → 0xFFFFFF80.
  - LBU 0x103 → 0x00000080.
  - LH 0x102 → 0xFFFF8012.
  - LHU 0x100 → 0x00003456.
- Stores:
  - SB 0x201, wdata 0x000000AB → `mem_addr`=0x200, mask 0010, `mem_wdata`=0xABABABAB.
  - SH 0x202, wdata 0x00001234 → mask 1100, 0x12341234.
  - SW → mask 1111.
- Illegal requests:
  - LW 0x102 → `rsp_valid`+`rsp_err` in N+1, no strobe, `rsp_rdata`=0.
  - Same result for LH 0x101, funct3=011, and simultaneous `req_load`+`req_store`.
- Busy and timeout:
  - `mem_wbusy` high 3 WAIT cycles → `rsp_valid` in N+6, err=0.
  - `WAIT_MAX`=4 with `mem_rbusy` stuck high → `rsp_valid`+err in N+6.
  - A following request completes normally.
- Reset and ignored requests:
  - `rstn` low during WAIT → all outputs 0 at once, no `rsp_valid`.
  - After release, LW succeeds with the nominal 3-cycle latency.
  - A request pulsed while `busy` is high is ignored.
